// File: rtl/data_mem_bridge.sv
// M-stage data-side bridge: formats stores, runs one SRAM-like bus transaction at a time,
// extends load data into a held result register and raises d_stall until that result is ready.
module data_mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  input  logic        load_unsigned,
  input  logic        stall_others,
  output logic [31:0] mem_rdata,
  output logic        d_stall,
  output logic        addr_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wen_q, wen_d;
  logic        uns_q, uns_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access_ok;
  logic [3:0]  in_wstrb;
  logic [31:0] in_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // A misaligned access behaves exactly like an empty slot.
  assign addr_err  = mem_en & (((mem_size == 2'd1) & mem_addr[0]) |
                               ((mem_size == 2'd2) & (mem_addr[1:0] != 2'b00)));
  assign access_ok = mem_en & ~addr_err;
  assign d_stall   = access_ok & (state_q != DONE);
  assign mem_rdata = rdata_q;
  assign dbg_state = state_q;

  always_comb begin
    in_wstrb = 4'b1111;
    in_wdata = mem_wdata;
    case (mem_size)
      2'd0: begin
        in_wstrb = 4'b0001 << mem_addr[1:0];
        in_wdata = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        in_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
        in_wdata = {2{mem_wdata[15:0]}};
      end
      default: in_wstrb = 4'b1111;
    endcase
    if (!mem_wen) in_wstrb = 4'b0000;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = data_rdata[7:0];
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      default: byte_sel = data_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_data = data_rdata;
    endcase
  end

  // Bus handshake: data_req is asserted from the first request cycle through the cycle
  // data_addr_ok is sampled high (inclusive) and is never withdrawn once raised; bus fields
  // are stable while it is high. data_data_ok completes the single outstanding transaction.
  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wen_d      = wen_q;
    uns_d      = uns_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    data_req   = 1'b0;
    data_wr    = wen_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wstrb = wstrb_q;
    data_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        cancel_d   = 1'b0;
        data_wr    = mem_wen;
        data_size  = mem_size;
        data_addr  = mem_addr;
        data_wstrb = in_wstrb;
        data_wdata = in_wdata;
        if (access_ok) begin
          data_req = 1'b1;
          addr_d   = mem_addr;
          size_d   = mem_size;
          wen_d    = mem_wen;
          uns_d    = load_unsigned;
          wstrb_d  = in_wstrb;
          wdata_d  = in_wdata;
          state_d  = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        data_req = 1'b1;
        if (!access_ok) cancel_d = 1'b1;
        if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (!access_ok) cancel_d = 1'b1;
        if (data_data_ok) begin
          // The instruction must still be present to take the response.
          if (cancel_q || !access_ok) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            if (!wen_q) rdata_d = load_data;
          end
        end
      end
      DONE: begin
        cancel_d = 1'b0;
        if (!stall_others) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_addr  = 32'd0;
      data_wstrb = 4'b0000;
      data_wdata = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      addr_q   <= 32'd0;
      size_q   <= 2'd0;
      wen_q    <= 1'b0;
      uns_q    <= 1'b0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      uns_q    <= uns_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: transaction-level reference model of the bridge, directed
// cases with literal expectations, then a randomized pipeline plus randomized bus slave.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wen, load_unsigned, stall_others;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        d_stall, addr_err, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  dbg_state;

  data_mem_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .load_unsigned(load_unsigned),
    .stall_others(stall_others), .mem_rdata(mem_rdata), .d_stall(d_stall),
    .addr_err(addr_err), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] strobe(input logic wen, input logic [1:0] sz, input logic [31:0] a);
    int n, base;
    logic [3:0] s;
    n = nbytes(sz);
    base = (int'(a[1:0]) / n) * n;
    s = 4'b0000;
    if (wen)
      for (int i = 0; i < 4; i++)
        if (i >= base && i < base + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] r;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [31:0] a,
                                          input logic [1:0] sz, input logic uns);
    int n, base;
    logic [31:0] v, mask;
    n = nbytes(sz);
    base = (int'(a[1:0]) / n) * n;
    v = d >> (8 * base);
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Transaction bookkeeping: request open on the bus, response awaited,
  // result held for the pipeline, instruction abandoned while in flight.
  logic        m_req_open, m_resp_open, m_held, m_flushed;
  logic        m_wen, m_uns;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        advance;

  task automatic model_reset();
    m_req_open = 0; m_resp_open = 0; m_held = 0; m_flushed = 0;
    m_wen = 0; m_uns = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    exp_q.delete();
  endtask

  function automatic logic instr_valid();
    return mem_en && !misaligned(mem_size, mem_addr);
  endfunction

  function automatic logic bus_idle();
    return !(m_req_open || m_resp_open || m_held);
  endfunction

  function automatic logic model_req();
    return !rst && (bus_idle() ? instr_valid() : m_req_open);
  endfunction

  // Compare every DUT output against the model, #1 after the falling edge.
  task automatic probe();
    logic e_req, e_dstall;
    #1;
    e_req = model_req();
    e_dstall = instr_valid() && !m_held;
    chk1("addr_err", addr_err, mem_en && misaligned(mem_size, mem_addr));
    chk1("data_req", data_req, e_req);
    chk1("d_stall", d_stall, e_dstall);
    chk32("mem_rdata", mem_rdata, m_rdata);
    if (exp_q.size() != 0) chk32("load_result", mem_rdata, exp_q.pop_front());
    if (rst) begin
      chk1("rst_wr", data_wr, 1'b0);
      chk32("rst_addr", data_addr, 32'd0);
      chk32("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
      chk32("rst_wdata", data_wdata, 32'd0);
    end else if (e_req) begin
      if (bus_idle()) begin
        chk1("req_wr", data_wr, mem_wen);
        chk32("req_size", {30'd0, data_size}, {30'd0, mem_size});
        chk32("req_addr", data_addr, mem_addr);
        chk32("req_wstrb", {28'd0, data_wstrb}, {28'd0, strobe(mem_wen, mem_size, mem_addr)});
        chk32("req_wdata", data_wdata, lanes(mem_size, mem_wdata));
      end else begin
        chk1("hold_wr", data_wr, m_wen);
        chk32("hold_size", {30'd0, data_size}, {30'd0, m_size});
        chk32("hold_addr", data_addr, m_addr);
        chk32("hold_wstrb", {28'd0, data_wstrb}, {28'd0, strobe(m_wen, m_size, m_addr)});
        chk32("hold_wdata", data_wdata, lanes(m_size, m_wdata));
      end
    end
    advance = !e_dstall && !stall_others;
  endtask

  // Advance the model across the next rising edge, then return to the falling edge.
  task automatic tick();
    logic valid, gone;
    valid = instr_valid();
    if (rst) begin
      model_reset();
    end else if (bus_idle()) begin
      if (valid) begin
        m_addr = mem_addr; m_size = mem_size; m_wen = mem_wen;
        m_uns = load_unsigned; m_wdata = mem_wdata; m_flushed = 0;
        if (data_addr_ok) m_resp_open = 1; else m_req_open = 1;
      end
    end else if (m_req_open) begin
      if (!valid) m_flushed = 1;
      if (data_addr_ok) begin m_req_open = 0; m_resp_open = 1; end
    end else if (m_resp_open) begin
      gone = m_flushed || !valid;
      if (!valid) m_flushed = 1;
      if (data_data_ok) begin
        m_resp_open = 0;
        if (!gone) begin
          m_held = 1;
          if (!m_wen) begin
            m_rdata = extract(data_rdata, m_addr, m_size, m_uns);
            exp_q.push_back(m_rdata);
          end
        end
      end
    end else if (m_held) begin
      if (!stall_others) m_held = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ins(input logic en, input logic wen, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd, input logic uns);
    mem_en = en; mem_wen = wen; mem_addr = a; mem_size = sz; mem_wdata = wd; load_unsigned = uns;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
    probe();
  endtask

  task automatic bubble();
    set_ins(0, 0, 32'd0, 2'd0, 32'd0, 0);
    stall_others = 0;
    bus(0, 0, 32'd0);
    tick();
  endtask

  task automatic new_ins();
    logic [1:0] sz;
    logic [31:0] a;
    sz = 2'($urandom_range(0, 3));
    a = $urandom;
    if ($urandom_range(0, 99) < 80) begin
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
    end
    set_ins($urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), a, sz, $urandom,
            1'($urandom_range(0, 1)));
  endtask

  // Minimum-latency load: addr_ok in cycle 0, data_ok in cycle 1, result in cycle 2.
  task automatic min_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] rd, input logic [31:0] expect_v);
    set_ins(1, 0, a, sz, 32'd0, uns);
    stall_others = 0;
    bus(1, 0, 32'd0);
    chk1({tag, "_stall_c0"}, d_stall, 1'b1);
    tick();
    bus(0, 1, rd);
    chk1({tag, "_stall_c1"}, d_stall, 1'b1);
    tick();
    bus(0, 0, 32'd0);
    chk1({tag, "_stall_c2"}, d_stall, 1'b0);
    chk32({tag, "_rdata"}, mem_rdata, expect_v);
    tick();
    bubble();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    set_ins(0, 0, 32'd0, 2'd0, 32'd0, 0);
    stall_others = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    model_reset();
    advance = 0;
    repeat (3) @(negedge clk);
    bus(0, 0, 32'd0);
    chk32("reset_rdata", mem_rdata, 32'd0);
    chk1("reset_req", data_req, 1'b0);
    tick();
    rst = 0;
    bubble();

    min_load("lw", 32'h0000_1000, 2'd2, 0, 32'h8000_00F0, 32'h8000_00F0);
    min_load("lb", 32'h0000_1003, 2'd0, 0, 32'h8012_3456, 32'hFFFF_FF80);
    min_load("lbu", 32'h0000_1003, 2'd0, 1, 32'h8012_3456, 32'h0000_0080);

    // sh held three cycles before acceptance
    set_ins(1, 1, 32'h0000_2002, 2'd1, 32'h1234_ABCD, 0);
    for (int k = 0; k < 3; k++) begin
      bus(k == 2, 0, 32'd0);
      chk1("sh_req", data_req, 1'b1);
      chk1("sh_wr", data_wr, 1'b1);
      chk32("sh_wstrb", {28'd0, data_wstrb}, 32'h0000_000C);
      chk32("sh_wdata", data_wdata, 32'hABCD_ABCD);
      tick();
    end
    bus(0, 1, 32'd0);
    tick();
    bus(0, 0, 32'd0);
    chk1("sh_done_stall", d_stall, 1'b0);
    chk32("sh_keeps_rdata", mem_rdata, 32'h0000_0080);
    tick();
    bubble();

    // misaligned word load
    set_ins(1, 0, 32'h0000_3001, 2'd2, 32'd0, 0);
    bus(0, 0, 32'd0);
    chk1("mis_err", addr_err, 1'b1);
    chk1("mis_req", data_req, 1'b0);
    chk1("mis_stall", d_stall, 1'b0);
    tick();
    bubble();

    // load flushed while awaiting its response, followed by a store
    set_ins(1, 0, 32'h0000_6000, 2'd2, 32'd0, 0);
    bus(1, 0, 32'd0);
    tick();
    mem_en = 0;
    bus(0, 0, 32'd0);
    tick();
    set_ins(1, 1, 32'h0000_7000, 2'd2, 32'hCAFE_F00D, 0);
    bus(0, 1, 32'hDEAD_BEEF);
    chk1("drain_req", data_req, 1'b0);
    chk1("drain_stall", d_stall, 1'b1);
    tick();
    bus(1, 0, 32'd0);
    chk1("sw_req", data_req, 1'b1);
    chk32("sw_addr", data_addr, 32'h0000_7000);
    chk32("drain_rdata", mem_rdata, 32'h0000_0080);
    tick();
    bus(0, 1, 32'd0);
    tick();
    bus(0, 0, 32'd0);
    chk1("sw_done_stall", d_stall, 1'b0);
    tick();
    bubble();

    // result held under an external stall
    set_ins(1, 0, 32'h0000_8006, 2'd1, 32'd0, 0);
    bus(1, 0, 32'd0);
    tick();
    bus(0, 1, 32'h7FFE_1234);
    tick();
    stall_others = 1;
    for (int k = 0; k < 4; k++) begin
      bus(0, 0, 32'd0);
      chk1("hold_noreq", data_req, 1'b0);
      chk1("hold_stall", d_stall, 1'b0);
      chk32("hold_rdata", mem_rdata, 32'h0000_7FFE);
      tick();
    end
    stall_others = 0;
    bus(0, 0, 32'd0);
    tick();
    bubble();

    // reset while a store awaits its response
    set_ins(1, 1, 32'h0000_5000, 2'd2, 32'h1122_3344, 0);
    bus(1, 0, 32'd0);
    tick();
    bus(0, 0, 32'd0);
    chk1("wait_stall", d_stall, 1'b1);
    #2 rst = 1;
    #1;
    chk1("rst_req_now", data_req, 1'b0);
    chk32("rst_wstrb_now", {28'd0, data_wstrb}, 32'd0);
    chk32("rst_wdata_now", data_wdata, 32'd0);
    chk32("rst_addr_now", data_addr, 32'd0);
    chk32("rst_rdata_now", mem_rdata, 32'd0);
    model_reset();
    @(negedge clk);
    bus(0, 0, 32'd0);
    tick();
    set_ins(0, 0, 32'd0, 2'd0, 32'd0, 0);
    rst = 0;
    bubble();

    // randomized pipeline against a randomized bus slave
    for (int c = 0; c < 2000; c++) begin
      if (advance) new_ins();
      else if ((m_req_open || m_resp_open) && $urandom_range(0, 99) < 8) mem_en = 0;
      stall_others = $urandom_range(0, 99) < 30;
      data_addr_ok = model_req() && ($urandom_range(0, 99) < 45);
      data_data_ok = m_resp_open && ($urandom_range(0, 99) < 40);
      data_rdata = $urandom;
      probe();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Memory-stage data-side bridge between the pipeline's M-stage memory control signals and an SRAM-like data bus (req / addr_ok / data_ok). Downstream consumer of the datapath's aluoutM / writedataM and M-stage memory controls; upstream producer of the d_cache_stall used by the hazard unit. It formats stores (byte strobes and lane replication), tracks one outstanding transaction through a small FSM, extracts and extends load data, and holds the result until the pipeline advances.

## Interface
- No parameters; data bus is 32 bits, byte-addressed.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_en  in  1  M-stage load/store valid; already gated by exception flush.
- mem_wen  in  1  1 = store, 0 = load.
- mem_addr  in  32  effective address (aluoutM).
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- mem_wdata  in  32  raw rt value (writedataM), right-aligned.
- load_unsigned  in  1  1 = zero-extend loads (lbu/lhu).
- stall_others  in  1  OR of non-data stall sources (alu_stall, ifetch stall).
- mem_rdata  out  32  extended load result, registered.
- d_stall  out  1  data-side stall to the hazard unit.
- addr_err  out  1  misaligned access detected; combinational.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  bus size (= mem_size).
- data_addr  out  32  bus address (unmodified mem_addr).
- data_wstrb  out  4  byte enables.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or write-complete.
- data_rdata  in  32  read data, valid with data_data_ok.

## Operation
- addr_err = mem_en & ((size==1 & addr[0]) | (size==2 & addr[1:0]!=0)). A misaligned access is treated as mem_en = 0: no request is issued and no stall is raised.
- wstrb values:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - loads: 4'b0000
- wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- States are IDLE, REQ, WAIT and DONE. A cancel flag is set whenever mem_en falls while in REQ or WAIT.
- IDLE:
  - With a valid aligned mem_en and rst low, drive data_req = 1 combinationally from the inputs, and latch addr, size, wen, wstrb, wdata and load_unsigned.
  - If addr_ok arrives in the same cycle, go to WAIT; otherwise go to REQ.
- REQ:
  - Hold data_req and all bus fields from the latched copies until addr_ok, then go to WAIT.
  - A request that has been issued is never withdrawn, even if cancel is set.
- WAIT:
  - On data_ok with cancel = 0, go to DONE. For loads, register the extracted data into mem_rdata.
  - On data_ok with cancel = 1, discard the response and go to IDLE.
- Load extraction uses the latched addr and size:
  - byte: lane addr[1:0], sign- or zero-extended.
  - half: lane addr[1], sign- or zero-extended.
  - word: passed through.
- DONE:
  - Return to IDLE when stall_others = 0.
  - Otherwise stay in DONE and issue no new request.
- d_stall = mem_en & ~addr_err & (state != DONE). While a cancelled transaction drains, a new mem_en instruction stalls until the FSM reaches IDLE, then issues normally.
- Stores leave mem_rdata unchanged.

## Timing
- Reset (asynchronous):
  - state = IDLE, cancel = 0, mem_rdata = 0.
  - data_req, data_wr, data_wstrb, data_wdata and data_addr are forced to 0 while rst is high.
  - A transaction in flight when rst asserts is abandoned.
- Minimum load latency, with addr_ok in cycle 0 and data_ok in cycle 1:
  - d_stall is high in cycles 0 and 1.
  - mem_rdata is valid and d_stall is low in cycle 2 (DONE).
  - The pipeline advances at the end of cycle 2.
- Handshake: data_req stays high from the first request cycle through the cycle of addr_ok inclusive. There is exactly one outstanding transaction.
- data_ok arriving while in IDLE or REQ is ignored. The bus guarantees this does not occur.

## Test plan
- lw at 0x1000, addr_ok in cycle 0, data_ok in cycle 1 with rdata 0x8000_00F0 -> d_stall = 1,1,0; mem_rdata = 0x8000_00F0 in cycle 2.
- lb at 0x1003, rdata 0x80xx_xxxx, load_unsigned = 0 -> mem_rdata = 0xFFFF_FF80. The same access as lbu -> 0x0000_0080.
- sh at 0x2002 with wdata 0x1234_ABCD -> data_wr = 1, wstrb = 4'b1100, data_wdata = 0xABCD_ABCD, request held for 3 cycles until addr_ok.
- lw at 0x3001 -> addr_err = 1, data_req = 0, d_stall = 0.
- Load accepted, then mem_en drops in WAIT (flush), then a new sw is presented -> old data_ok is discarded, mem_rdata unchanged, sw request issued the cycle after the drain.
- stall_others = 1 during DONE for 4 cycles -> FSM stays in DONE, no second request, mem_rdata stable. Separately, rst asserted in WAIT -> all outputs 0 immediately.
